// File: rtl/digest_serializer_if.sv
// Byte stream link for digest_serializer.
// Master drives data/valid/last, slave returns ready.
interface digest_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/digest_serializer.sv
// Captures a digest on its valid pulse and streams it MSB-first.
// DIGEST_SERIALIZER_HEX_ASCII_EN selects lowercase hex text plus LF.
module digest_serializer #(
  parameter int DIGEST_W = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [DIGEST_W-1:0] hash_in,
  input  logic                hash_valid_in,
  digest_serializer_if.master tx,
  output logic                busy,
  output logic                overrun
);

  localparam int NB = DIGEST_W / 8;
`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
  localparam int NBEATS = 2 * NB + 1;
`else
  localparam int NBEATS = NB;
`endif
  localparam logic [6:0] LAST = 7'(NBEATS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]          state;
  logic [DIGEST_W-1:0] shreg;
  logic [6:0]          cnt;

  logic sending;
  logic cap;
  logic beat;
  logic last_beat;
  logic shift_now;
  logic [7:0] beat_byte;
`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
  logic [3:0] nib;
`endif

  assign sending   = (state == SEND);
  assign cap       = hash_valid_in && enable;
  assign beat      = sending && tx.tx_ready;
  assign last_beat = beat && (cnt == LAST);

`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
  // Two characters per byte: drop the byte after its low nibble.
  assign shift_now = cnt[0];
`else
  assign shift_now = 1'b1;
`endif

  // Format the byte presented for the current beat.
  always_comb begin
    beat_byte = 8'h00;
`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
    nib = cnt[0] ? shreg[DIGEST_W-5 -: 4]
                 : shreg[DIGEST_W-1 -: 4];
    if (cnt == LAST)
      beat_byte = 8'h0a;
    else if (nib < 4'd10)
      beat_byte = 8'h30 + {4'h0, nib};
    else
      beat_byte = 8'h57 + {4'h0, nib};
`else
    beat_byte = shreg[DIGEST_W-1 -: 8];
`endif
  end

  assign tx.tx_valid = sending;
  assign tx.tx_data  = sending ? beat_byte : 8'h00;
  assign tx.tx_last  = sending && (cnt == LAST);
  assign busy        = sending;

  // Capture, beat sequencing and back-to-back reload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cap) begin
            shreg <= hash_in;
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (last_beat) begin
            if (cap) begin
              shreg <= hash_in;
              cnt   <= '0;
            end else begin
              shreg <= '0;
              cnt   <= '0;
              state <= IDLE;
            end
          end else if (beat) begin
            cnt <= cnt + 7'd1;
            if (shift_now)
              shreg <= shreg << 8;
          end
        end
        default: begin
          state <= IDLE;
          shreg <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Sticky flag for digests that arrive while one is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n)
      overrun <= 1'b0;
    else if (sending && hash_valid_in && !last_beat)
      overrun <= 1'b1;
  end

endmodule

// File: tb/tb_digest_serializer.sv
// Directed plus random bench for digest_serializer.
// Model follows DIGEST_SERIALIZER_HEX_ASCII_EN like the design.
module tb_digest_serializer;

  localparam int NB = 32;
`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
  localparam int NBEATS = 2 * NB + 1;
`else
  localparam int NBEATS = NB;
`endif
  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [255:0] hash_in;
  logic         hash_valid_in;
  logic         busy;
  logic         overrun;

  digest_serializer_if txif ();

  digest_serializer #(.DIGEST_W(256)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .hash_in       (hash_in),
    .hash_valid_in (hash_valid_in),
    .tx            (txif),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r = (r << 32) | 256'($urandom);
    return r;
  endfunction

  function automatic logic [7:0] hexc(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'(87 + n);
  endfunction

  // Expected beat list straight from the digest value.
  task automatic build_exp(input logic [255:0] d);
    int b;
    exp_q.delete();
    for (int i = 0; i < NB; i++) begin
      b = int'((d >> (8 * (NB - 1 - i))) & 256'hff);
`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
      exp_q.push_back(hexc(b / 16));
      exp_q.push_back(hexc(b % 16));
`else
      exp_q.push_back(8'(b));
`endif
    end
`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
    exp_q.push_back(8'h0a);
`endif
  endtask

  task automatic pulse(input logic [255:0] d);
    hash_in       = d;
    hash_valid_in = 1'b1;
    enable        = 1'b1;
    txif.tx_ready = 1'b1;
    step();
    hash_valid_in = 1'b0;
    chk("first_valid", 64'(txif.tx_valid), 64'd1);
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random.
  task automatic drain(input int mode, input int drop_idx,
                       input int acc_idx, input logic [255:0] acc_d);
    int   idx;
    int   cyc;
    logic rdy;
    bit   dropped;
    bit   drop_now;
    idx = 0;
    cyc = 0;
    dropped = 1'b0;
    while (exp_q.size() > 0) begin
      if (cyc >= 2000) begin
        chk("timeout", 64'd0, 64'd1);
        break;
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 3 == 0);
      else rdy = 1'($urandom_range(0, 1));
      txif.tx_ready = rdy;
      hash_valid_in = 1'b0;
      hash_in = rand256();
      if (mode == 2) enable = 1'($urandom_range(0, 1));
      drop_now = rdy && (idx == drop_idx);
      if (drop_now) begin
        hash_valid_in = 1'b1;
        hash_in = '1;
        enable = 1'b1;
      end
      if (rdy && idx == acc_idx) begin
        hash_valid_in = 1'b1;
        hash_in = acc_d;
        enable = 1'b1;
      end
      chk("tx_valid", 64'(txif.tx_valid), 64'd1);
      if (txif.tx_valid !== 1'b1) break;
      chk("busy", 64'(busy), 64'd1);
      chk("tx_data", 64'(txif.tx_data), 64'(exp_q[0]));
      chk("tx_last", 64'(txif.tx_last), 64'(exp_q.size() == 1));
      if (dropped) chk("overrun_set", 64'(overrun), 64'd1);
      if (rdy) begin
        void'(exp_q.pop_front());
        idx++;
      end
      step();
      cyc++;
      if (drop_now) dropped = 1'b1;
    end
    hash_valid_in = 1'b0;
    chk("beat_count", 64'(idx), 64'(NBEATS));
    if (acc_idx == NBEATS - 1) begin
      chk("b2b_valid", 64'(txif.tx_valid), 64'd1);
      chk("b2b_busy", 64'(busy), 64'd1);
    end else begin
      chk("end_valid", 64'(txif.tx_valid), 64'd0);
      chk("end_busy", 64'(busy), 64'd0);
      chk("end_last", 64'(txif.tx_last), 64'd0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    hash_in       = '0;
    hash_valid_in = 1'b0;
    txif.tx_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(txif.tx_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_last", 64'(txif.tx_last), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_data", 64'(txif.tx_data), 64'd0);
    rst_n = 1'b1;

    enable        = 1'b0;
    hash_in       = ABC;
    hash_valid_in = 1'b1;
    txif.tx_ready = 1'b1;
    step();
    hash_valid_in = 1'b0;
    chk("gate_valid", 64'(txif.tx_valid), 64'd0);
    chk("gate_busy", 64'(busy), 64'd0);
    chk("gate_overrun", 64'(overrun), 64'd0);
    step();
    chk("gate_idle", 64'(txif.tx_valid), 64'd0);

    build_exp(ABC);
    pulse(ABC);
    drain(0, -1, -1, '0);

    build_exp(ABC);
    pulse(ABC);
    drain(1, -1, -1, '0);

    build_exp(ABC);
    pulse(ABC);
    drain(0, 5, NBEATS - 1, '0);
    chk("ovr_kept", 64'(overrun), 64'd1);
    build_exp('0);
    drain(0, -1, -1, '0);
    chk("ovr_sticky", 64'(overrun), 64'd1);

    build_exp(ABC);
    pulse(ABC);
    txif.tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_valid", 64'(txif.tx_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_last", 64'(txif.tx_last), 64'd0);
    chk("mid_overrun", 64'(overrun), 64'd0);
    build_exp(ABC);
    pulse(ABC);
    drain(0, -1, -1, '0);

    for (int k = 0; k < 4; k++) begin
      logic [255:0] d;
      d = rand256();
      build_exp(d);
      pulse(d);
      drain(2, -1, -1, '0);
    end
    chk("rand_overrun", 64'(overrun), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
